// File: rtl/capture_controller.sv
// capture_controller
//
// Sequencer and BRAM arbiter for the shared 28x28 frame buffer (784 x 16-bit words,
// single-port BRAM with one cycle of read latency). Each capture runs
// clear -> wait for frame start -> capture -> hand-off. The camera writer owns the
// BRAM during capture. The inference reader owns it otherwise.
//
// Optional feature: define CAPTURE_TIMEOUT_EN to add a watchdog that aborts a
// capture stuck in ARM/CAPTURE for TIMEOUT_CYC cycles without a vsync edge.
//
// Ports:
//   pclk, rst_n          clock, synchronous active-low reset
//   start                one-cycle capture request (ignored while busy)
//   vsync                camera frame sync (pclk domain, high in vertical blank)
//   cam_active           enables the camera writer
//   cam_en/we/addr/din   camera writer BRAM request (forwarded only in CAPTURE).
//                        The camera writer reads bram_dout directly.
//   rd_req/rd_addr       reader request, held until rd_gnt
//   rd_gnt               reader accepted this cycle (combinational)
//   rd_valid/rd_data     read result, two cycles after the grant
//   bram_en/we/addr/din  registered BRAM port
//   bram_dout            BRAM read data, valid one cycle after bram_en
//   busy                 high in CLEAR, ARM, CAPTURE, FLUSH
//   frame_ready          buffer holds a completed capture
//   drop_err             sticky: camera access seen outside CAPTURE
//   timeout              sticky watchdog flag (0 unless CAPTURE_TIMEOUT_EN)

module capture_controller #(
    parameter int unsigned DEPTH       = 784,
    parameter int unsigned AW          = 10,
    parameter int unsigned DW          = 16,
    parameter int unsigned FRAMES      = 1,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          vsync,
    output logic          cam_active,
    input  logic          cam_en,
    input  logic          cam_we,
    input  logic [AW-1:0] cam_addr,
    input  logic [DW-1:0] cam_din,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout,
    output logic          busy,
    output logic          frame_ready,
    output logic          drop_err,
    output logic          timeout
);

    if (FRAMES < 1 || FRAMES > 15 || TIMEOUT_CYC < 1 || DEPTH > (1 << AW)) begin : g_cfg_err
        $error("capture_controller: illegal parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArm,
        StCapture,
        StFlush,
        StReady
    } state_e;

    localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
    localparam logic [3:0]    FramesLim = 4'(FRAMES);

    state_e        state;
    logic          vsync_q;
    logic          vs_edge;
    logic          reader_owns;
    logic [AW-1:0] clr_cnt;
    logic          clr_done;
    logic [3:0]    frm_cnt;
    logic          rd_pend;

    assign vs_edge     = vsync & ~vsync_q;
    assign reader_owns = (state == StIdle) || (state == StReady);
    assign busy        = ~reader_owns;

    // A start in the same cycle takes the BRAM, so the reader keeps waiting.
    assign rd_gnt  = rd_req & reader_owns & ~start;
    assign rd_data = rd_valid ? bram_dout : '0;

`ifdef CAPTURE_TIMEOUT_EN
    localparam logic [31:0] WdLast = 32'(TIMEOUT_CYC - 1);
    logic [31:0] wd_cnt;
    logic        timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state       <= StIdle;
            vsync_q     <= 1'b1;  // vsync already high at release is not an edge
            clr_cnt     <= '0;
            clr_done    <= 1'b0;
            frm_cnt     <= '0;
            rd_pend     <= 1'b0;
            rd_valid    <= 1'b0;
            cam_active  <= 1'b0;
            bram_en     <= 1'b0;
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            frame_ready <= 1'b0;
            drop_err    <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
            wd_cnt      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            vsync_q  <= vsync;
            rd_pend  <= 1'b0;
            rd_valid <= rd_pend;
            bram_en  <= 1'b0;
            bram_we  <= 1'b0;

            if (cam_en && state != StCapture) begin
                drop_err <= 1'b1;
            end

            unique case (state)
                StIdle, StReady: begin
                    if (start) begin
                        state       <= StClear;
                        frame_ready <= 1'b0;
                        drop_err    <= 1'b0;
                        clr_cnt     <= '0;
                        clr_done    <= 1'b0;
                    end else if (rd_gnt) begin
                        bram_en   <= 1'b1;
                        bram_addr <= rd_addr;
                        rd_pend   <= 1'b1;
                    end
                end
                StClear: begin
                    // One extra cycle after the last write so ARM starts once
                    // address DEPTH-1 is already on the BRAM port.
                    if (clr_done) begin
                        state <= StArm;
                    end else begin
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b1;
                        bram_addr <= clr_cnt;
                        bram_din  <= '0;
                        if (clr_cnt == LastAddr) begin
                            clr_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + AW'(1);
                        end
                    end
                end
                StArm: begin
                    if (vs_edge) begin
                        state      <= StCapture;
                        cam_active <= 1'b1;
                        frm_cnt    <= '0;
                    end
                end
                StCapture: begin
                    bram_en   <= cam_en;
                    bram_we   <= cam_we;
                    bram_addr <= cam_addr;
                    bram_din  <= cam_din;
                    if (vs_edge) begin
                        frm_cnt <= frm_cnt + 4'd1;
                        if ((frm_cnt + 4'd1) == FramesLim) begin
                            cam_active <= 1'b0;
                            state      <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    // Last camera access retires on the BRAM port this cycle.
                    state       <= StReady;
                    frame_ready <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                end
            endcase

`ifdef CAPTURE_TIMEOUT_EN
            if (reader_owns && start) begin
                timeout_q <= 1'b0;
            end
            // Counter is held at 0 outside ARM/CAPTURE, which also restarts it on ARM entry.
            if (state == StArm || state == StCapture) begin
                if (vs_edge) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == WdLast) begin
                    state      <= StIdle;
                    cam_active <= 1'b0;
                    timeout_q  <= 1'b1;
                    wd_cnt     <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 32'd1;
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_capture_controller.sv
// tb_capture_controller
//
// Directed sequence with randomized camera traffic and reader requests. A reference
// image of the frame buffer (exp_mem) and a queue of expected read results are kept
// at transaction level and compared against the DUT and a simple BRAM model.

module tb_capture_controller;

    localparam int unsigned DEPTH = 784;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;

    logic          pclk;
    logic          rst_n;
    logic          start;
    logic          vsync;
    logic          cam_active;
    logic          cam_en;
    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_din;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic          busy;
    logic          frame_ready;
    logic          drop_err;
    logic          timeout;

    capture_controller #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .DW          (DW),
        .FRAMES      (1),
        .TIMEOUT_CYC (2000000)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .start       (start),
        .vsync       (vsync),
        .cam_active  (cam_active),
        .cam_en      (cam_en),
        .cam_we      (cam_we),
        .cam_addr    (cam_addr),
        .cam_din     (cam_din),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_dout   (bram_dout),
        .busy        (busy),
        .frame_ready (frame_ready),
        .drop_err    (drop_err),
        .timeout     (timeout)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Single-port BRAM, one cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_dout;
    always @(posedge pclk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else mem_dout <= mem[bram_addr];
        end
    end
    assign bram_dout = mem_dout;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic [DW-1:0] exp_mem [DEPTH];
    rd_exp_t       rd_q [$];
    int            cycle;
    int            passes;
    int            total;

    task automatic step();
        @(posedge pclk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cycle);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {cam_active, rd_gnt, rd_valid, bram_en, bram_we, busy, frame_ready,
                  drop_err, timeout}, 32'h0);
        chk({tag, "_bus"}, {bram_addr, bram_din}, 32'h0);
        chk({tag, "_rdata"}, rd_data, 32'h0);
    endtask

    task automatic check_rd_out();
        if (rd_q.size() > 0 && rd_q[0].due == cycle) begin
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, rd_q[0].data);
            void'(rd_q.pop_front());
        end else begin
            chk("rd_idle", rd_valid, 0);
        end
    endtask

    // Reader traffic while the buffer is READY. With keep_first the inputs already
    // driven for the current cycle are used as the first request.
    task automatic read_phase(input int n, input bit keep_first);
        for (int i = 0; i < n + 3; i++) begin
            check_rd_out();
            chk("ready_hold", {busy, frame_ready, cam_active}, 3'b010);
            if (i >= n) begin
                rd_req = 1'b0;
            end else if (!(keep_first && i == 0)) begin
                rd_req  = ($urandom_range(0, 3) != 0);
                rd_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            #1;
            chk("rd_gnt", rd_gnt, rd_req);
            if (rd_req) rd_q.push_back('{cycle + 2, exp_mem[rd_addr]});
            step();
        end
        chk("rd_drained", rd_q.size(), 0);
    endtask

    task automatic rand_cam();
        int a;
        a = $urandom_range(0, DEPTH - 1);
        if (a == 5) a = 6;  // keep address 5 for the directed read-back
        cam_en   = ($urandom_range(0, 1) == 1);
        cam_we   = ($urandom_range(0, 3) != 0);
        cam_addr = AW'(a);
        cam_din  = DW'($urandom);
    endtask

    logic [31:0] prev_cam;
    int          n_arm;
    int          n_cap;

    initial begin
        passes = 0;
        total  = 0;
        cycle  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        vsync  = 1'b1;
        cam_en = 1'b0;
        cam_we = 1'b0;
        cam_addr = '0;
        cam_din  = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all_zero("post_reset");
        end

        // vsync edges in IDLE do nothing.
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
        step();
        chk_all_zero("idle_vsync");
        vsync = 1'b0;
        step();

        // start together with a vsync edge, reader already requesting.
        start   = 1'b1;
        vsync   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = AW'(5);
        step();
        start = 1'b0;
        #1;
        chk("clear_entry", {busy, frame_ready, drop_err, timeout, bram_en, rd_gnt}, 6'b100000);
        for (int k = 0; k < DEPTH; k++) begin
            step();
            chk("clear_wr", {bram_en, bram_we, bram_addr, bram_din},
                {1'b1, 1'b1, AW'(k), 16'h0000});
            chk("clear_hold", {busy, rd_gnt, cam_active}, 3'b100);
        end

        // ARM: the edge coincident with start must not count.
        step();
        chk("arm_entry", {busy, bram_en, cam_active, rd_gnt}, 4'b1000);
        vsync = 1'b0;
        n_arm = $urandom_range(3, 8);
        for (int i = 0; i < n_arm; i++) begin
            step();
            chk("arm_wait", {busy, bram_en, cam_active, rd_gnt}, 4'b1000);
        end
        vsync = 1'b1;
        step();
        chk("cap_entry", {busy, cam_active, rd_gnt}, 3'b110);

        // CAPTURE: camera traffic forwarded one cycle later; start pulse ignored.
        n_cap = $urandom_range(25, 40);
        for (int j = 0; j < n_cap; j++) begin
            if (j == 0) begin
                cam_en   = 1'b1;
                cam_we   = 1'b1;
                cam_addr = AW'(5);
                cam_din  = 16'h1234;
            end else begin
                rand_cam();
            end
            if (j == 8) vsync = 1'b0;
            start = (j == 15);
            prev_cam = {4'h0, cam_en, cam_we, cam_addr, cam_din};
            if (cam_en && cam_we) exp_mem[cam_addr] = cam_din;
            step();
            chk("cam_fwd", {bram_en, bram_we, bram_addr, bram_din}, prev_cam);
            chk("cap_hold", {busy, cam_active, rd_gnt, frame_ready, drop_err}, 5'b11000);
        end
        start = 1'b0;

        // Terminating edge at cycle e, with a camera access in the same cycle.
        vsync = 1'b1;
        rand_cam();
        prev_cam = {4'h0, cam_en, cam_we, cam_addr, cam_din};
        if (cam_en && cam_we) exp_mem[cam_addr] = cam_din;
        step();
        chk("flush_fwd", {bram_en, bram_we, bram_addr, bram_din}, prev_cam);
        chk("flush_state", {busy, cam_active, frame_ready, rd_gnt}, 4'b1000);
        cam_en = 1'b0;
        cam_we = 1'b0;
        step();
        chk("ready_entry", {busy, cam_active, frame_ready, drop_err, timeout}, 5'b00100);

        // First grant on the first READY cycle (addr 5 held since start).
        read_phase(24, 1'b1);

        // Camera access in READY: ignored, flags drop_err.
        cam_en   = 1'b1;
        cam_we   = 1'b1;
        cam_addr = AW'(5);
        cam_din  = 16'hBEEF;
        step();
        cam_en = 1'b0;
        cam_we = 1'b0;
        chk("drop_set", {drop_err, bram_en, frame_ready, busy}, 4'b1010);
        rd_req  = 1'b1;
        rd_addr = AW'(5);
        read_phase(6, 1'b1);
        chk("drop_sticky", drop_err, 1);

        // Next start clears the flags; reset in the middle of CLEAR.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart", {busy, frame_ready, drop_err, timeout}, 4'b1000);
        repeat (50) step();
        chk("restart_clear", {bram_en, bram_we, bram_addr}, {1'b1, 1'b1, AW'(49)});
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_all_zero("mid_reset");
        step();
        chk_all_zero("after_reset");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
